seq_match_sched: RTL and testbench

- Round-robin scheduler that shares one 2-bit-symbol pattern detector among NCH requesters.
- The detector is the existing `counting`-style FSM: input `num[1:0]`, output `ans`, no enable.
  - It advances every clock.
  - It asserts `ans` when it has seen the run 1+, 2+, 3+.
  - A 0 symbol returns it to its start state.
- Grants one requester a whole burst of symbols, steers them onto the detector and counts match cycles.
- Reports a per-burst match count, then flushes the detector before the next grant.

---
 rtl/seq_match_sched_if.sv | 26 ++
 rtl/seq_match_sched.sv | 145 ++++++++++++++
 tb/tb_seq_match_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_match_sched_if.sv
// Request, detector and result signals of the shared-detector scheduler.
// slave = scheduler side, master = requesters/detector/result consumer side.
interface seq_match_sched_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    logic [NCH-1:0]   req_valid;
    logic [2*NCH-1:0] req_num;
    logic [NCH-1:0]   req_last;
    logic [NCH-1:0]   req_ready;
    logic [1:0]       det_num;
    logic             det_ans;
    logic             res_valid;
    logic [1:0]       res_chan;
    logic [CNT_W-1:0] res_count;

    modport slave (
        input  req_valid, req_num, req_last, det_ans,
        output req_ready, det_num, res_valid, res_chan, res_count
    );

    modport master (
        output req_valid, req_num, req_last, det_ans,
        input  req_ready, det_num, res_valid, res_chan, res_count
    );
endinterface

// File: rtl/seq_match_sched.sv
// Round-robin scheduler sharing one 2-bit-symbol pattern detector among NCH
// requesters; grants whole bursts, counts match cycles, reports per burst.
module seq_match_sched #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_match_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BURST  = 2'd1,
        S_FLUSH  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [1:0]       LAST_CH = 2'(NCH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_g;
    logic [1:0]       r_last_g;
    logic [CNT_W-1:0] r_cnt;
    logic             r_acc_d;
    logic             r_res_valid;
    logic [1:0]       r_res_chan;
    logic [CNT_W-1:0] r_res_count;

    logic [2:0]       w_idx;
    logic [1:0]       w_pick;
    logic             w_any;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [1:0]       w_sel_num;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;
    logic [NCH-1:0]   w_grant_oh;

    // Round-robin pick: first requester after the previous grant, modulo NCH.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last_g;
        w_idx  = 3'd0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx  = {1'b0, r_last_g} + 3'(k);
            w_idx  = (w_idx >= 3'(NCH)) ? (w_idx - 3'(NCH)) : w_idx;
            w_pick = (!w_any && bus.req_valid[w_idx[1:0]]) ? w_idx[1:0] : w_pick;
            w_any  = w_any | bus.req_valid[w_idx[1:0]];
        end
    end

    assign w_sel_valid = bus.req_valid[r_g];
    assign w_sel_last  = bus.req_last[r_g];
    assign w_sel_num   = bus.req_num[{r_g, 1'b0} +: 2];
    assign w_accept    = (r_state == S_BURST) && w_sel_valid;
    assign w_grant_oh  = {{(NCH-1){1'b0}}, 1'b1} << r_g;

    // det_ans belongs to the symbol accepted one cycle earlier, hence acc_d.
    assign w_cnt_next = (r_acc_d && bus.det_ans)
                      ? ((r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE))
                      : r_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_any ? S_BURST : S_IDLE;
            S_BURST:  w_next = (w_accept && w_sel_last) ? S_FLUSH : S_BURST;
            S_FLUSH:  w_next = S_REPORT;
            S_REPORT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Handshake and detector drive; zero symbols during reset clear the detector.
    always_comb begin
        bus.req_ready = {NCH{1'b0}};
        bus.det_num   = 2'd0;
        if (reset) begin
            bus.req_ready = {NCH{1'b0}};
            bus.det_num   = 2'd0;
        end else begin
            case (r_state)
                S_BURST: begin
                    bus.req_ready = w_grant_oh;
                    bus.det_num   = w_sel_valid ? w_sel_num : 2'd0;
                end
                default: begin
                    bus.req_ready = {NCH{1'b0}};
                    bus.det_num   = 2'd0;
                end
            endcase
        end
    end

    // Grant, match counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_g         <= 2'd0;
            r_last_g    <= LAST_CH;
            r_cnt       <= {CNT_W{1'b0}};
            r_acc_d     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_chan  <= 2'd0;
            r_res_count <= {CNT_W{1'b0}};
        end else begin
            r_res_valid <= (r_state == S_FLUSH);
            r_acc_d     <= w_accept;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_g      <= w_pick;
                        r_last_g <= w_pick;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt    <= r_cnt;
                    end
                end
                S_BURST: r_cnt <= w_cnt_next;
                S_FLUSH: begin
                    r_cnt       <= w_cnt_next;
                    r_res_chan  <= r_g;
                    r_res_count <= w_cnt_next;
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.res_valid = r_res_valid;
    assign bus.res_chan  = r_res_chan;
    assign bus.res_count = r_res_count;
endmodule

// File: tb/tb_seq_match_sched.sv
// Table-driven bench for seq_match_sched with a behavioural model of the
// shared run detector (1+, 2+, 3+ -> ans; 0 returns to start).
module tb_seq_match_sched;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_match_sched_if #(.NCH(4), .CNT_W(8)) ifa ();
    seq_match_sched_if #(.NCH(4), .CNT_W(2)) ifb ();

    seq_match_sched #(.NCH(4), .CNT_W(8)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    seq_match_sched #(.NCH(4), .CNT_W(2)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    // Detector model: 0 start, 1 seen 1+, 2 seen 1+2+, 3 match (ans).
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic [1:0] n);
        case (n)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            2'd2:    return (s == 2'd1 || s == 2'd2) ? 2'd2 : 2'd0;
            2'd3:    return (s == 2'd2 || s == 2'd3) ? 2'd3 : 2'd0;
            default: return 2'd0;
        endcase
    endfunction

    logic [1:0] det_sa = 2'd0;
    logic [1:0] det_sb = 2'd0;
    always @(posedge clk) det_sa <= det_next(det_sa, ifa.det_num);
    always @(posedge clk) det_sb <= det_next(det_sb, ifb.det_num);
    assign ifa.det_ans = (det_sa == 2'd3);
    assign ifb.det_ans = (det_sb == 2'd3);

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [7:0] n;
        logic [3:0] l;
        logic [3:0] e_rdy;
        logic [1:0] e_dn;
        logic       e_rv;
        logic [1:0] e_ch;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [3:0] v, input logic [7:0] n,
                       input logic [3:0] l, input logic [3:0] e_rdy, input logic [1:0] e_dn,
                       input logic e_rv, input logic [1:0] e_ch, input logic [7:0] e_cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.n = n; t.l = l;
        t.e_rdy = e_rdy; t.e_dn = e_dn; t.e_rv = e_rv; t.e_ch = e_ch; t.e_cnt = e_cnt;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic b_cyc(input int idx, input logic [3:0] v, input logic [7:0] n, input logic [3:0] l,
                         input logic [1:0] e_dn, input logic e_rv, input logic [7:0] e_cnt);
        @(negedge clk);
        ifb.req_valid = v; ifb.req_num = n; ifb.req_last = l;
        #1;
        chk("b_det_num", idx, 32'(ifb.det_num), 32'(e_dn));
        chk("b_res_valid", idx, 32'(ifb.res_valid), 32'(e_rv));
        if (e_rv) begin
            chk("b_res_count", idx, 32'(ifb.res_count), 32'(e_cnt));
            chk("b_res_chan", idx, 32'(ifb.res_chan), 32'd0);
        end
    endtask

    logic [3:0] rows_v;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.req_valid = 4'd0; ifa.req_num = 8'd0; ifa.req_last = 4'd0;
        ifb.req_valid = 4'd0; ifb.req_num = 8'd0; ifb.req_last = 4'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 0, 32'(ifa.req_ready), 32'd0);
        chk("rst_det_num", 0, 32'(ifa.det_num), 32'd0);
        chk("rst_res_valid", 0, 32'(ifa.res_valid), 32'd0);
        chk("rst_res_chan", 0, 32'(ifa.res_chan), 32'd0);
        chk("rst_res_count", 0, 32'(ifa.res_count), 32'd0);

        // Channel 0: 1,2,3 -> one match, report 2 cycles after the last accept.
        add(1'b0, 4'b0001, 8'h01, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0001, 8'h01, 4'b0000, 4'b0001, 2'd1, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0001, 8'h02, 4'b0000, 4'b0001, 2'd2, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0001, 8'h03, 4'b0001, 4'b0001, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b1, 2'd0, 8'd1);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        // Channel 2: 1,1,2,2,3,3,3 -> three matches.
        add(1'b0, 4'b0100, 8'h10, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h10, 4'b0000, 4'b0100, 2'd1, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h10, 4'b0000, 4'b0100, 2'd1, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h20, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h20, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0100, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h30, 4'b0000, 4'b0100, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0100, 8'h30, 4'b0100, 4'b0100, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b1, 2'd2, 8'd3);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        // Channel 1: 1,2,bubble,3 -> bubble drives 0, no match.
        add(1'b0, 4'b0010, 8'h04, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0010, 8'h04, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0010, 8'h08, 4'b0000, 4'b0010, 2'd2, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h0C, 4'b0000, 4'b0010, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0010, 8'h0C, 4'b0010, 4'b0010, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b1, 2'd1, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        // Reset, then all channels requesting 1-symbol bursts: grants 0,1,2,3,0.
        add(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1111, 8'h55, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            rows_v = (k == 4) ? 4'b0000 : 4'b1111;
            add(1'b0, 4'b1111, 8'h55, 4'b1111, 4'b0001 << (k % 4), 2'd1, 1'b0, 2'd0, 8'd0);
            add(1'b0, 4'b1111, 8'h55, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
            add(1'b0, 4'b1111, 8'h55, 4'b1111, 4'b0000, 2'd0, 1'b1, 2'(k % 4), 8'd0);
            add(1'b0, rows_v, 8'h55, 4'b1111, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        end
        // Channel 3 sends 1,2, reset aborts; next burst 3,3 starts from a clean detector.
        add(1'b0, 4'b1000, 8'h40, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1000, 8'h40, 4'b0000, 4'b1000, 2'd1, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1000, 8'h80, 4'b0000, 4'b1000, 2'd2, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b1000, 8'hC0, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1000, 8'hC0, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1000, 8'hC0, 4'b0000, 4'b1000, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1000, 8'hC0, 4'b1000, 4'b1000, 2'd3, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b1, 2'd3, 8'd0);
        add(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0, 8'd0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_a = vq[i].rst;
            ifa.req_valid = vq[i].v; ifa.req_num = vq[i].n; ifa.req_last = vq[i].l;
            #1;
            chk("req_ready", i, 32'(ifa.req_ready), 32'(vq[i].e_rdy));
            chk("det_num", i, 32'(ifa.det_num), 32'(vq[i].e_dn));
            chk("res_valid", i, 32'(ifa.res_valid), 32'(vq[i].e_rv));
            if (vq[i].e_rv) begin
                chk("res_chan", i, 32'(ifa.res_chan), 32'(vq[i].e_ch));
                chk("res_count", i, 32'(ifa.res_count), 32'(vq[i].e_cnt));
            end
        end

        // CNT_W=2 instance: five matching 3s saturate the counter at 3.
        @(negedge clk);
        rst_b = 1'b0;
        b_cyc(0, 4'b0001, 8'h01, 4'b0000, 2'd0, 1'b0, 8'd0);
        b_cyc(1, 4'b0001, 8'h01, 4'b0000, 2'd1, 1'b0, 8'd0);
        b_cyc(2, 4'b0001, 8'h02, 4'b0000, 2'd2, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            b_cyc(3 + k, 4'b0001, 8'h03, (k == 4) ? 4'b0001 : 4'b0000, 2'd3, 1'b0, 8'd0);
        end
        b_cyc(8, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b0, 8'd0);
        b_cyc(9, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b1, 8'd3);
        b_cyc(10, 4'b0000, 8'h00, 4'b0000, 2'd0, 1'b0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
